// File: rtl/bp_pkg.sv
// Shared types and constants for the BP buffer write-back path:
// beat geometry, the write-back FSM encoding and the buffer column index helper.
package bp_pkg;

    localparam int X_MAC          = 4;
    localparam int X_MESH         = 16;
    localparam int DDR_ADDR_LEN   = 32;
    localparam int ADDR_LEN       = 16;
    localparam int DATA_LEN       = 32;
    localparam int SINGLE_LEN     = 24;
    localparam int BUFFER_NUM     = X_MAC * X_MESH;
    localparam int WORDS_PER_BEAT = X_MESH;
    localparam int BEAT_W         = DATA_LEN * WORDS_PER_BEAT;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_READ  = 2'd1,
        WB_DRAIN = 2'd2
    } wb_state_t;

    // Buffer index of mesh row j in MAC column c (c + 4*j).
    function automatic logic [5:0] col_index(input logic [1:0] c, input int j);
        logic [3:0] row;
        row = 4'(j);
        return {row, c};
    endfunction

endpackage

// File: rtl/bp_writeback_control_if.sv
// BP buffer read port and DDR write-FIFO channel seen by the write-back controller.
interface bp_writeback_control_if;
    import bp_pkg::*;

    logic                           ddr_wfifo_full;
    logic                           ddr_wfifo_wr;
    logic [BEAT_W-1:0]              ddr_wfifo_data;
    logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out;
    logic [BUFFER_NUM-1:0]          BP_rd_en;
    logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_in;

    modport master (
        input  ddr_wfifo_full,
        output ddr_wfifo_wr,
        output ddr_wfifo_data,
        output BP_addr_out,
        output BP_rd_en,
        input  BP_data_in
    );

    modport slave (
        output ddr_wfifo_full,
        input  ddr_wfifo_wr,
        input  ddr_wfifo_data,
        input  BP_addr_out,
        input  BP_rd_en,
        output BP_data_in
    );

endinterface

// File: rtl/bp_wb_skid_fifo.sv
// Small synchronous FIFO holding packed beats between buffer capture and the
// DDR write FIFO; exposes occupancy so the reader can throttle itself.
module bp_wb_skid_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = BEAT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r != (PTR_W+1)'(DEPTH));
    assign pop_ok_s  = pop && (count_r != '0);

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + (PTR_W+1)'(push_ok_s) - (PTR_W+1)'(pop_ok_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == '0);

endmodule

// File: rtl/bp_writeback_control.sv
// Reads two lines of one-column beats out of the BP buffer bank, packs each
// column of 16 words into a 512-bit beat and streams the beats into the DDR write FIFO.
module bp_writeback_control
    import bp_pkg::*;
#(
    parameter int SKID_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    conf,
    input  logic [SINGLE_LEN-1:0]   data_ddr_byte,
    input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
    input  logic [ADDR_LEN-1:0]     BP_st_addr,
    input  logic [1:0]              BP_st_num,
    input  logic [SINGLE_LEN-1:0]   Line_width,
    output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]   ddr_len,
    output logic                    ddr_conf,
    output logic                    idle,
    bp_writeback_control_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = WB_IDLE;
    localparam logic [1:0] ST_READ  = WB_READ;
    localparam logic [1:0] ST_DRAIN = WB_DRAIN;
    localparam int         CNT_W    = $clog2(SKID_DEPTH) + 1;

    logic [1:0]              state_r, state_nxt_s;
    logic                    idle_r;
    logic [SINGLE_LEN-1:0]   width_r;
    logic [ADDR_LEN-1:0]     base_r;
    logic [1:0]              col0_r;
    logic [SINGLE_LEN:0]     iss_cnt_r;
    logic                    iss_r;
    logic [1:0]              iss_col_r;
    logic                    cap_r;
    logic [1:0]              cap_col_r;
    logic [BUFFER_NUM-1:0]   rd_en_r;
    logic [ADDR_LEN-1:0]     addr_r;

    logic                    acc_s;
    logic [SINGLE_LEN-1:0]   width_s;
    logic [ADDR_LEN-1:0]     base_s;
    logic [1:0]              col0_s;
    logic [SINGLE_LEN:0]     k_s, total_s, off_s;
    logic                    line_s;
    logic [1:0]              col_s;
    logic [ADDR_LEN-1:0]     addr_s;
    logic                    credit_s;
    logic                    issue_s;
    logic                    last_s;
    logic [BUFFER_NUM-1:0]   rd_mask_s;
    logic [BEAT_W-1:0]       beat_s;
    logic [BEAT_W-1:0]       head_s;
    logic [CNT_W-1:0]        skid_count_s;
    logic [CNT_W-1:0]        count_nxt_s;
    logic                    skid_empty_s;
    logic                    pop_s;

    assign acc_s = conf && (state_r == ST_IDLE) && (Line_width != '0);

    // On the accept cycle the first read is issued straight from the inputs,
    // which is what gives BP_rd_en in the cycle right after conf.
    assign width_s = acc_s ? Line_width : width_r;
    assign base_s  = acc_s ? BP_st_addr : base_r;
    assign col0_s  = acc_s ? BP_st_num  : col0_r;
    assign k_s     = acc_s ? '0 : iss_cnt_r;
    assign total_s = {width_s, 1'b0};
    assign line_s  = (k_s >= {1'b0, width_s});
    assign off_s   = line_s ? (k_s - {1'b0, width_s}) : k_s;
    assign col_s   = col0_s + {1'b0, line_s};
    assign addr_s  = base_s + off_s[ADDR_LEN-1:0];
    assign last_s  = ((k_s + (SINGLE_LEN+1)'(1)) == total_s);

    // Conservative credit: a beat already being popped is not counted as freed.
    assign credit_s = ({1'b0, skid_count_s} + (CNT_W+1)'(cap_r) + (CNT_W+1)'(iss_r))
                      < (CNT_W+1)'(SKID_DEPTH);
    assign issue_s  = (acc_s || (state_r == ST_READ)) && (k_s < total_s) && credit_s;

    assign pop_s       = !skid_empty_s && !bus.ddr_wfifo_full;
    assign count_nxt_s = skid_count_s + CNT_W'(cap_r) - CNT_W'(pop_s);

    // One-hot-per-row read enable for the selected MAC column.
    always_comb begin
        rd_mask_s = '0;
        for (int j = 0; j < WORDS_PER_BEAT; j++) begin
            rd_mask_s[col_index(col_s, j)] = 1'b1;
        end
    end

    // Pack the captured column (row j -> word j) into one beat.
    always_comb begin
        beat_s = '0;
        for (int j = 0; j < WORDS_PER_BEAT; j++) begin
            beat_s[j*DATA_LEN +: DATA_LEN] =
                bus.BP_data_in[int'(col_index(cap_col_r, j))*DATA_LEN +: DATA_LEN];
        end
    end

    // Next-state logic; DRAIN leaves as soon as the skid will be empty next cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s && last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (!iss_r && !cap_r && (count_nxt_s == '0)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Job latching, descriptor, read issue and capture pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            idle_r          <= 1'b1;
            width_r         <= '0;
            base_r          <= '0;
            col0_r          <= '0;
            iss_cnt_r       <= '0;
            iss_r           <= 1'b0;
            iss_col_r       <= '0;
            cap_r           <= 1'b0;
            cap_col_r       <= '0;
            rd_en_r         <= '0;
            addr_r          <= '0;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
            ddr_conf        <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            idle_r   <= (state_nxt_s == ST_IDLE);
            ddr_conf <= acc_s;
            if (acc_s) begin
                width_r         <= Line_width;
                base_r          <= BP_st_addr;
                col0_r          <= BP_st_num;
                ddr_st_addr_out <= ddr_st_addr;
                ddr_len         <= data_ddr_byte;
            end
            if (issue_s) begin
                rd_en_r   <= rd_mask_s;
                addr_r    <= addr_s;
                iss_cnt_r <= k_s + (SINGLE_LEN+1)'(1);
                iss_r     <= 1'b1;
                iss_col_r <= col_s;
            end else begin
                rd_en_r   <= '0;
                iss_r     <= 1'b0;
            end
            cap_r     <= iss_r;
            cap_col_r <= iss_col_r;
        end
    end

    bp_wb_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_r),
        .push_data (beat_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (skid_count_s),
        .empty     (skid_empty_s)
    );

    assign idle               = idle_r;
    assign bus.BP_rd_en       = rd_en_r;
    assign bus.BP_addr_out    = {BUFFER_NUM{addr_r}};
    assign bus.ddr_wfifo_wr   = pop_s;
    assign bus.ddr_wfifo_data = skid_empty_s ? '0 : head_s;

endmodule

// File: tb/tb_bp_writeback_control.sv
// Randomized bench for bp_writeback_control: a buffer-bank model answers reads,
// and a job-level reference (expected issue list and beat list) checks everything.
module tb_bp_writeback_control;
    import bp_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n, conf;
    logic [SINGLE_LEN-1:0]   data_ddr_byte, Line_width;
    logic [DDR_ADDR_LEN-1:0] ddr_st_addr;
    logic [ADDR_LEN-1:0]     BP_st_addr;
    logic [1:0]              BP_st_num;
    logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
    logic [SINGLE_LEN-1:0]   ddr_len;
    logic                    ddr_conf, idle;

    bp_writeback_control_if bus();

    bp_writeback_control dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .conf            (conf),
        .data_ddr_byte   (data_ddr_byte),
        .ddr_st_addr     (ddr_st_addr),
        .BP_st_addr      (BP_st_addr),
        .BP_st_num       (BP_st_num),
        .Line_width      (Line_width),
        .ddr_st_addr_out (ddr_st_addr_out),
        .ddr_len         (ddr_len),
        .ddr_conf        (ddr_conf),
        .idle            (idle),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BUFFER_NUM-1:0] mask;
        logic [ADDR_LEN-1:0]   addr;
    } iss_t;

    iss_t                  exp_iss[$];
    logic [BEAT_W-1:0]     exp_beat[$];
    int                    n_checks, n_errors;
    int                    cyc, job_cyc, n_conf, n_wr, outstanding, max_out;
    int                    first_rd, first_wr, idle_rel, full_hold;
    bit                    full_mode;
    logic [BUFFER_NUM-1:0] prev_rd;
    logic [ADDR_LEN-1:0]   prev_addr;
    logic [7:0]            salt;
    logic [DDR_ADDR_LEN-1:0] exp_ddr_addr;
    logic [SINGLE_LEN-1:0] exp_len;

    task automatic check_eq(input string tag, input logic [BEAT_W-1:0] got,
                            input logic [BEAT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Content a buffer returns: identifies buffer, address and job.
    function automatic logic [DATA_LEN-1:0] word(input int b, input logic [ADDR_LEN-1:0] a,
                                                 input logic [7:0] s);
        return {8'(b), a, s};
    endfunction

    task automatic tick();
        int rel;
        iss_t e;
        logic [BEAT_W-1:0] eb;
        @(posedge clk);
        #1;
        cyc++;
        conf = 1'b0;
        for (int b = 0; b < BUFFER_NUM; b++) begin
            if (prev_rd[b]) bus.BP_data_in[b*DATA_LEN +: DATA_LEN] = word(b, prev_addr, salt);
        end
        if (full_mode) begin
            if (full_hold == 0) begin
                bus.ddr_wfifo_full = ~bus.ddr_wfifo_full;
                full_hold = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(1, 4));
            end
            full_hold--;
        end else begin
            bus.ddr_wfifo_full = 1'b0;
        end
        @(negedge clk);
        rel       = cyc - job_cyc;
        prev_rd   = bus.BP_rd_en;
        prev_addr = bus.BP_addr_out[ADDR_LEN-1:0];
        if (ddr_conf) begin
            n_conf++;
            check_eq("conf_latency", 512'(rel), 512'(1));
            check_eq("ddr_addr", 512'(ddr_st_addr_out), 512'(exp_ddr_addr));
            check_eq("ddr_len", 512'(ddr_len), 512'(exp_len));
        end
        if (bus.BP_rd_en != '0) begin
            if (first_rd < 0) first_rd = rel;
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
            check_eq("credit", 512'(outstanding <= 4), 512'(1));
            if (exp_iss.size() == 0) begin
                check_eq("extra_issue", 512'(1), 512'(0));
            end else begin
                e = exp_iss.pop_front();
                check_eq("rd_mask", 512'(bus.BP_rd_en), 512'(e.mask));
                check_eq("rd_addr0", 512'(bus.BP_addr_out[ADDR_LEN-1:0]), 512'(e.addr));
                check_eq("rd_addr63", 512'(bus.BP_addr_out[63*ADDR_LEN +: ADDR_LEN]), 512'(e.addr));
            end
        end
        if (bus.ddr_wfifo_wr) begin
            check_eq("wr_while_full", 512'(bus.ddr_wfifo_full), 512'(0));
            if (first_wr < 0) first_wr = rel;
            n_wr++;
            outstanding--;
            if (exp_beat.size() == 0) begin
                check_eq("extra_beat", 512'(1), 512'(0));
            end else begin
                eb = exp_beat.pop_front();
                check_eq("beat", bus.ddr_wfifo_data, eb);
            end
        end
        if (idle && idle_rel < 0 && rel > 0) idle_rel = rel;
    endtask

    task automatic run_job(input logic [1:0] c0, input logic [ADDR_LEN-1:0] base, input int w,
                           input bit fm, input bit conf_again, input int rst_at);
        iss_t e;
        logic [BEAT_W-1:0] bt;
        logic [1:0] col;
        logic [ADDR_LEN-1:0] a;
        int rel;
        salt = salt + 8'd1;
        exp_iss.delete();
        exp_beat.delete();
        for (int ln = 0; ln < 2; ln++) begin
            col = c0 + 2'(ln);
            for (int off = 0; off < w; off++) begin
                a = base + ADDR_LEN'(off);
                e.mask = '0;
                for (int j = 0; j < X_MESH; j++) begin
                    e.mask[int'(col) + 4*j] = 1'b1;
                    bt[j*DATA_LEN +: DATA_LEN] = word(int'(col) + 4*j, a, salt);
                end
                e.addr = a;
                exp_iss.push_back(e);
                exp_beat.push_back(bt);
            end
        end
        full_mode = fm;
        if (fm) begin
            bus.ddr_wfifo_full = 1'b1;
            full_hold = 10;
        end
        BP_st_num     = c0;
        BP_st_addr    = base;
        Line_width    = SINGLE_LEN'(w);
        ddr_st_addr   = $urandom;
        data_ddr_byte = SINGLE_LEN'(128 * w);
        exp_ddr_addr  = ddr_st_addr;
        exp_len       = data_ddr_byte;
        n_conf = 0; n_wr = 0; outstanding = 0; max_out = 0;
        first_rd = -1; first_wr = -1; idle_rel = -1;
        job_cyc = cyc;
        conf = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rel = cyc - job_cyc;
            if (conf_again && rel == 3) begin
                conf        = 1'b1;
                ddr_st_addr = ~ddr_st_addr;
                Line_width  = SINGLE_LEN'(5);
            end
            if (rst_at >= 0 && rel == rst_at) begin
                rst_n = 1'b0;
                tick();
                check_eq("rst_conf", 512'(ddr_conf), 512'(0));
                check_eq("rst_idle", 512'(idle), 512'(1));
                check_eq("rst_wr", 512'(bus.ddr_wfifo_wr), 512'(0));
                check_eq("rst_rd_en", 512'(bus.BP_rd_en), 512'(0));
                check_eq("rst_addr", 512'(|bus.BP_addr_out), 512'(0));
                check_eq("rst_data", bus.ddr_wfifo_data, 512'(0));
                check_eq("rst_ddr_addr", 512'(ddr_st_addr_out), 512'(0));
                check_eq("rst_ddr_len", 512'(ddr_len), 512'(0));
                rst_n = 1'b1;
                exp_iss.delete();
                exp_beat.delete();
                full_mode = 1'b0;
                return;
            end
            if (idle && exp_beat.size() == 0 && rel > 1) break;
        end
        check_eq("issues_left", 512'(exp_iss.size()), 512'(0));
        check_eq("beats_left", 512'(exp_beat.size()), 512'(0));
        check_eq("n_wr", 512'(n_wr), 512'(2 * w));
        check_eq("n_conf", 512'(n_conf), 512'(1));
        check_eq("first_rd", 512'(first_rd), 512'(1));
        check_eq("addr_hold", 512'(ddr_st_addr_out), 512'(exp_ddr_addr));
        if (!fm) begin
            check_eq("first_wr", 512'(first_wr), 512'(3));
            check_eq("idle_return", 512'(idle_rel), 512'(2 * w + 3));
        end else if (2 * w >= 4) begin
            check_eq("credit_reached", 512'(max_out), 512'(4));
        end
        full_mode = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; conf = 1'b0;
        data_ddr_byte = '0; Line_width = '0; ddr_st_addr = '0;
        BP_st_addr = '0; BP_st_num = '0;
        bus.ddr_wfifo_full = 1'b0;
        bus.BP_data_in = '0;
        prev_rd = '0; prev_addr = '0; salt = 8'd0;
        cyc = 0; job_cyc = 0; full_mode = 1'b0; full_hold = 0;
        n_checks = 0; n_errors = 0;
        n_conf = 0; n_wr = 0; outstanding = 0; max_out = 0;
        first_rd = -1; first_wr = -1; idle_rel = -1;
        repeat (3) tick();
        check_eq("reset_idle", 512'(idle), 512'(1));
        check_eq("reset_conf", 512'(ddr_conf), 512'(0));
        check_eq("reset_wr", 512'(bus.ddr_wfifo_wr), 512'(0));
        check_eq("reset_rd_en", 512'(bus.BP_rd_en), 512'(0));
        check_eq("reset_data", bus.ddr_wfifo_data, 512'(0));
        rst_n = 1'b1;
        tick();

        run_job(2'd1, 16'h0010, 4, 1'b0, 1'b0, -1);
        run_job(2'd3, 16'h0040, 2, 1'b0, 1'b0, -1);
        run_job(2'd2, 16'h0100, 16, 1'b1, 1'b0, -1);
        run_job(2'd0, 16'h0007, 6, 1'b0, 1'b1, -1);

        // conf with zero width while idle must be ignored
        n_conf = 0;
        Line_width = '0;
        conf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("zero_width_idle", 512'(idle), 512'(1));
        end
        check_eq("zero_width_conf", 512'(n_conf), 512'(0));

        run_job(2'd1, 16'h0020, 8, 1'b0, 1'b0, 5);
        run_job(2'd2, 16'h0030, 8, 1'b0, 1'b0, -1);
        run_job(2'd0, 16'hFFFE, 4, 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            run_job(2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(1, 9)),
                    1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
